// File: rtl/tlb_pkg.sv
// Shared state encoding, entry layout and default widths for the TLB controller.
package tlb_pkg;

  localparam int TLB_VPN_W    = 6;
  localparam int TLB_PPN_W    = 2;
  localparam int TLB_OFFSET_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    FETCH,
    RESP
  } tlb_state_e;

  // Entry layout follows the package widths; the controller's width parameters default to these.
  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic                 ref_b;
    logic [TLB_VPN_W-1:0] vpn;
    logic [TLB_PPN_W-1:0] ppn;
  } tlb_entry_t;

endpackage

// File: rtl/tlb_lru.sv
// Age-based true-LRU tracker: ages form a permutation of 0..ENTRIES-1, the oldest is the victim.
module tlb_lru
  import tlb_pkg::*;
#(
  parameter  int ENTRIES = 4,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             touch_i,
  input  logic [IDX_W-1:0] touch_idx_i,
  output logic [IDX_W-1:0] victim_o
);

  logic [IDX_W-1:0] age_q [ENTRIES];
  logic [IDX_W-1:0] age_d [ENTRIES];

  always_comb begin
    victim_o = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (age_q[i] == IDX_W'(ENTRIES - 1)) victim_o = IDX_W'(i);
    end
  end

  // Touched entry becomes youngest; only entries younger than it age by one.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) age_d[i] = age_q[i];
    if (touch_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (IDX_W'(i) == touch_idx_i) begin
          age_d[i] = '0;
        end else if (age_q[i] < age_q[touch_idx_i]) begin
          age_d[i] = age_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) age_q[i] <= IDX_W'(i);
    end else begin
      for (int i = 0; i < ENTRIES; i++) age_q[i] <= age_d[i];
    end
  end

endmodule

// File: rtl/tlb_ctrl.sv
// Fully associative LRU TLB in front of the page table: dirty-victim write-back, then fetch on a miss.
// Defining TLB_STATS_EN adds saturating hit/miss counters and their output ports.
module tlb_ctrl
  import tlb_pkg::*;
#(
  parameter int ENTRIES  = 4,
  parameter int VPN_W    = TLB_VPN_W,
  parameter int PPN_W    = TLB_PPN_W,
  parameter int OFFSET_W = TLB_OFFSET_W
`ifdef TLB_STATS_EN
  ,
  parameter int CNT_W    = 16
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
`ifdef TLB_STATS_EN
  output logic [CNT_W-1:0]          hit_count,
  output logic [CNT_W-1:0]          miss_count,
`endif
  input  logic                      cpu_req_valid,
  output logic                      cpu_req_ready,
  input  logic                      cpu_req_write,
  input  logic [VPN_W+OFFSET_W-1:0] cpu_vaddr,
  output logic                      cpu_resp_valid,
  output logic [PPN_W+OFFSET_W-1:0] cpu_paddr,
  output logic                      cpu_resp_fault,
  output logic                      pt_req_valid,
  output logic                      pt_req_write,
  output logic [VPN_W-1:0]          pt_vpn,
  output logic [PPN_W-1:0]          pt_ppn_out,
  input  logic                      pt_done,
  input  logic [PPN_W-1:0]          pt_ppn_in,
  input  logic                      pt_page_fault
);

  localparam int IDX_W = $clog2(ENTRIES);

  tlb_state_e                state_q, state_d;
  tlb_entry_t                entries_q [ENTRIES];
  logic [VPN_W+OFFSET_W-1:0] vaddr_q;
  logic                      write_q;
  logic                      hit_q;
  logic                      fault_q;
  logic [IDX_W-1:0]          idx_q;

  logic [VPN_W-1:0]          req_vpn;
  logic [VPN_W-1:0]          lat_vpn;
  logic                      hit;
  logic [IDX_W-1:0]          hit_idx;
  logic                      inv_found;
  logic [IDX_W-1:0]          inv_idx;
  logic [IDX_W-1:0]          lru_victim;
  logic [IDX_W-1:0]          victim;
  logic                      touch;

  assign req_vpn = cpu_vaddr[VPN_W+OFFSET_W-1:OFFSET_W];
  assign lat_vpn = vaddr_q[VPN_W+OFFSET_W-1:OFFSET_W];

  // Descending scan so the lowest-index invalid entry is the one left in inv_idx.
  always_comb begin
    hit       = 1'b0;
    hit_idx   = '0;
    inv_found = 1'b0;
    inv_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (entries_q[i].valid && entries_q[i].vpn == req_vpn) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!entries_q[i].valid) begin
        inv_found = 1'b1;
        inv_idx   = IDX_W'(i);
      end
    end
  end

  assign victim = inv_found ? inv_idx : lru_victim;
  assign touch  = (state_q == RESP) && !fault_q;

  tlb_lru #(
    .ENTRIES(ENTRIES)
  ) u_lru (
    .clk        (clk),
    .reset      (reset),
    .touch_i    (touch),
    .touch_idx_i(idx_q),
    .victim_o   (lru_victim)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_paddr      = '0;
    cpu_resp_fault = 1'b0;
    pt_req_valid   = 1'b0;
    pt_req_write   = 1'b0;
    pt_vpn         = '0;
    pt_ppn_out     = '0;
    case (state_q)
      IDLE: begin
        cpu_req_ready = 1'b1;
        if (cpu_req_valid) begin
          if (hit)                                                     state_d = RESP;
          else if (entries_q[victim].valid && entries_q[victim].dirty) state_d = WB;
          else                                                         state_d = FETCH;
        end
      end
      WB: begin
        pt_req_valid = 1'b1;
        pt_req_write = 1'b1;
        pt_vpn       = entries_q[idx_q].vpn;
        pt_ppn_out   = entries_q[idx_q].ppn;
        if (pt_done) state_d = FETCH;
      end
      FETCH: begin
        pt_req_valid = 1'b1;
        pt_vpn       = lat_vpn;
        if (pt_done) state_d = RESP;
      end
      RESP: begin
        cpu_resp_valid = 1'b1;
        cpu_resp_fault = fault_q;
        if (!fault_q) cpu_paddr = {entries_q[idx_q].ppn, vaddr_q[OFFSET_W-1:0]};
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) entries_q[i] <= '0;
      vaddr_q <= '0;
      write_q <= 1'b0;
      hit_q   <= 1'b0;
      fault_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (cpu_req_valid) begin
          vaddr_q <= cpu_vaddr;
          write_q <= cpu_req_write;
          hit_q   <= hit;
          fault_q <= 1'b0;
          idx_q   <= hit ? hit_idx : victim;
        end
        WB: if (pt_done) entries_q[idx_q].dirty <= 1'b0;
        FETCH: if (pt_done) begin
          // A faulting fetch leaves the victim entry exactly as it was.
          if (pt_page_fault) begin
            fault_q <= 1'b1;
          end else begin
            entries_q[idx_q].valid <= 1'b1;
            entries_q[idx_q].ref_b <= 1'b1;
            entries_q[idx_q].dirty <= write_q;
            entries_q[idx_q].vpn   <= lat_vpn;
            entries_q[idx_q].ppn   <= pt_ppn_in;
          end
        end
        RESP: if (hit_q) begin
          entries_q[idx_q].ref_b <= 1'b1;
          if (write_q) entries_q[idx_q].dirty <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef TLB_STATS_EN
  logic [CNT_W-1:0] hit_cnt_q;
  logic [CNT_W-1:0] miss_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == IDLE && cpu_req_valid) begin
      if (hit) begin
        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
      end else begin
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: doc/tlb_ctrl.md
Name: tlb_ctrl

Overview:
Fully associative, LRU-replaced TLB controller sitting directly upstream of the page table, between the CPU address path and the page table. Translates CPU virtual addresses to physical addresses. On a miss it writes back the dirty victim's ref/dirty state to the page table, then fetches the missing translation. Reports page faults to the CPU without filling the entry.

Parameters:
ENTRIES, 4, number of TLB entries (power of 2, >=2)
VPN_W, 6, virtual page number width
PPN_W, 2, physical page number width
OFFSET_W, 8, page offset width (passed through untranslated)
CNT_W, 16, statistics counter width (TLB_STATS_EN only)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
cpu_req_valid  in  1  translation request
cpu_req_ready  out  1  high only in IDLE
cpu_req_write  in  1  1 = store (sets dirty), 0 = load
cpu_vaddr  in  VPN_W+OFFSET_W  virtual address
cpu_resp_valid  out  1  one-cycle pulse, response valid
cpu_paddr  out  PPN_W+OFFSET_W  translated address
cpu_resp_fault  out  1  page fault, qualified by cpu_resp_valid
pt_req_valid  out  1  page-table request, held until pt_done
pt_req_write  out  1  1 = write back entry, 0 = read translation
pt_vpn  out  VPN_W  page-table index
pt_ppn_out  out  PPN_W  PPN written back (pt_req_write=1)
pt_done  in  1  page-table completion, sampled only while pt_req_valid=1
pt_ppn_in  in  PPN_W  fetched PPN, valid with pt_done
pt_page_fault  in  1  fetch fault, valid with pt_done
hit_count, miss_count  out  CNT_W  statistics (TLB_STATS_EN only)

Behaviour:
- Reset (async): all entries valid=0, dirty=0; ages = entry index; FSM=IDLE. All outputs 0 except cpu_req_ready=1.
- Entry fields: valid, dirty, ref, vpn[VPN_W], ppn[PPN_W], age[log2 ENTRIES].
- States: IDLE, WB, FETCH, RESP.
- IDLE:
  - On cpu_req_valid, latch vaddr/write and run the combinational compare over all valid entries.
  - Hit: enter RESP.
  - Miss: choose the victim. The lowest-index invalid entry wins; otherwise the entry with age = ENTRIES-1.
  - Victim valid and dirty -> WB. Otherwise -> FETCH.
- WB: pt_req_valid=1, pt_req_write=1, pt_vpn=victim vpn, pt_ppn_out=victim ppn. On pt_done, clear victim dirty and go to FETCH.
- FETCH: pt_req_valid=1, pt_req_write=0, pt_vpn=latched VPN.
  - pt_done with pt_page_fault=1: victim untouched; go to RESP with fault.
  - pt_done with pt_page_fault=0: fill victim with valid=1, ref=1, dirty=latched write, ppn=pt_ppn_in; go to RESP.
- RESP (one cycle): cpu_resp_valid=1.
  - No fault: cpu_paddr = {ppn, offset}, cpu_resp_fault=0.
  - Fault: cpu_paddr = 0, cpu_resp_fault=1.
  - On a hit, set ref=1 and, if write, dirty=1.
  - Return to IDLE.
- Latency:
  - Hit: request accepted at edge N, response at N+1.
  - Miss: 1 + (WB cycles) + (FETCH cycles) + 1.
  - pt_done arriving in the first request cycle counts as 1 cycle.
- LRU update on hit or fill only (a fault leaves ages unchanged): touched entry age=0; entries with age < old age increment. Ages stay a permutation of 0..ENTRIES-1.
- pt_req_valid drops in the cycle after pt_done is sampled. pt_done outside WB/FETCH is ignored.
- Reset mid-miss: outstanding page-table request abandoned; pt_req_valid=0 immediately.
- Duplicate VPNs never exist, since a fill occurs only after a miss.

Optional Feature:
TLB_STATS_EN:
- Defined: hit_count/miss_count ports exist; each increments once per accepted request (fault counts as a miss), saturating at all-ones, reset to 0.
- Undefined: ports and counters absent.

Decomposition:
- Shared package tlb_pkg holds:
  - state enum (IDLE/WB/FETCH/RESP)
  - tlb_entry_t struct
  - width constants VPN_W/PPN_W/OFFSET_W defaults
- One sub-module: tlb_lru, which owns the age array and exposes victim index, touch strobe and touched index.

Test Plan:
- Reset, then load vaddr 0x0412 (VPN 4); page table returns ppn 2 -> one WB-free FETCH, RESP with paddr 0x212, fault=0; repeat -> hit, resp at N+1, paddr 0x212.
- Load VPN 5 (invalid in page table, pt_page_fault=1) -> RESP fault=1, paddr=0; re-request VPN 5 -> FETCH again (no fill).
- Fill VPNs 0,1,7,8 with a store to VPN 0; touch 1,7,8; load VPN 10 -> victim VPN 0, WB with pt_vpn=0, pt_ppn_out=1, then FETCH VPN 10.
- pt_done delayed 5 cycles in FETCH -> pt_req_valid held 5 cycles, cpu_req_ready=0 throughout.
- Assert reset during FETCH -> pt_req_valid=0 same cycle, all entries invalid, next VPN 4 load misses.
- TLB_STATS_EN: 3 hits, 2 misses, 1 fault -> hit_count=3, miss_count=3.
